// File: rtl/int_mul_seq.sv
// int_mul_seq: multi-cycle shift-add integer multiplier, signed or unsigned.
// Ports:
//   clk, rst (sync, active-high)
//   start, A, B, sign : request and operands, taken when idle
//   busy, done, OUT   : in-flight flag, one-cycle done pulse, 2*WIDTH product
module int_mul_seq #(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    input  logic               sign,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] OUT
);

    localparam int PW = 2 * WIDTH;
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [PW-1:0]     acc_q, acc_d;
    logic [PW-1:0]     mcand_q, mcand_d;
    logic [WIDTH-1:0]  mplier_q, mplier_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              neg_q, neg_d;
    logic [PW-1:0]     out_q, out_d;
    logic              done_q, done_d;

    logic [WIDTH-1:0]  mag_a;
    logic [WIDTH-1:0]  mag_b;

    // The most negative value negates to itself, which read as unsigned is
    // exactly its magnitude, so no extra bit is needed.
    assign mag_a = (sign && A[WIDTH-1]) ? (~A + WIDTH'(1)) : A;
    assign mag_b = (sign && B[WIDTH-1]) ? (~B + WIDTH'(1)) : B;

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        neg_d    = neg_q;
        out_d    = out_q;
        done_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    mcand_d  = {{WIDTH{1'b0}}, mag_a};
                    mplier_d = mag_b;
                    neg_d    = sign & (A[WIDTH-1] ^ B[WIDTH-1]);
                    acc_d    = '0;
                    cnt_d    = '0;
                    state_d  = CALC;
                end
            end
            CALC: begin
                if (mplier_q[0]) begin
                    acc_d = acc_q + mcand_q;
                end
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    state_d = FIN;
                end
            end
            FIN: begin
                // Negating zero yields zero, so a zero product stays zero.
                out_d   = neg_q ? (~acc_q + PW'(1)) : acc_q;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            neg_q    <= 1'b0;
            out_q    <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
            neg_q    <= neg_d;
            out_q    <= out_d;
            done_q   <= done_d;
        end
    end

    assign busy = (state_q != IDLE);
    assign done = done_q;
    assign OUT  = out_q;

endmodule

// File: tb/tb_int_mul_seq.sv
// tb_int_mul_seq: directed checks of int_mul_seq at WIDTH=16.
// Inputs change and outputs are sampled on the falling edge.
module tb_int_mul_seq;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] A;
    logic [15:0] B;
    logic        sign;
    logic        busy;
    logic        done;
    logic [31:0] OUT;

    int pass_cnt = 0;
    int total_cnt = 0;

    int_mul_seq #(.WIDTH(16)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .A     (A),
        .B     (B),
        .sign  (sign),
        .busy  (busy),
        .done  (done),
        .OUT   (OUT)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive a request for one rising edge; returns at the falling edge
    // right after the accepting edge with start dropped.
    task automatic issue(input logic [15:0] a, input logic [15:0] b,
                         input logic s);
        @(negedge clk);
        A = a;
        B = b;
        sign = s;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Called at the falling edge after the accepting edge. Counts rising
    // edges until done is seen, busy samples, and done/busy overlap.
    task automatic wait_done(output int cyc, output int bcnt,
                             output bit ok, output bit overlap);
        cyc = 0;
        bcnt = busy ? 1 : 0;
        ok = 1'b0;
        overlap = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            if (busy && done) overlap = 1'b1;
            if (done) begin
                ok = 1'b1;
                break;
            end
            if (busy) bcnt++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b1;
        A = 16'h0003;
        B = 16'h0003;
        sign = 1'b0;
        repeat (3) @(negedge clk);
        total_cnt++;
        if (busy !== 1'b0)
            $display("FAIL reset_busy: got %b want 0", busy);
        else pass_cnt++;
        total_cnt++;
        if (done !== 1'b0)
            $display("FAIL reset_done: got %b want 0", done);
        else pass_cnt++;
        total_cnt++;
        if (OUT !== 32'h0)
            $display("FAIL reset_out: got %h want 00000000", OUT);
        else pass_cnt++;
        start = 1'b0;
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_unsigned_max();
        int cyc, bcnt;
        bit ok, ov;
        issue(16'hFFFF, 16'hFFFF, 1'b0);
        wait_done(cyc, bcnt, ok, ov);
        total_cnt++;
        if (!ok) $display("FAIL umax_timeout: no done within 100 clocks");
        else pass_cnt++;
        total_cnt++;
        if (OUT !== 32'hFFFE0001)
            $display("FAIL umax_out: got %h want fffe0001", OUT);
        else pass_cnt++;
        total_cnt++;
        if (cyc != 17)
            $display("FAIL umax_latency: got %0d want 17", cyc);
        else pass_cnt++;
        total_cnt++;
        if (bcnt != 17)
            $display("FAIL umax_busy_cycles: got %0d want 17", bcnt);
        else pass_cnt++;
        total_cnt++;
        if (ov) $display("FAIL umax_overlap: busy and done both 1 want never");
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (done !== 1'b0)
            $display("FAIL umax_done_pulse: got %b want 0", done);
        else pass_cnt++;
        total_cnt++;
        if (OUT !== 32'hFFFE0001)
            $display("FAIL umax_out_hold: got %h want fffe0001", OUT);
        else pass_cnt++;
    endtask

    task automatic test_mode();
        int cyc, bcnt;
        bit ok, ov;
        issue(16'hFFFF, 16'h0002, 1'b1);
        wait_done(cyc, bcnt, ok, ov);
        total_cnt++;
        if (!ok || OUT !== 32'hFFFFFFFE)
            $display("FAIL mode_signed: got %h want fffffffe", OUT);
        else pass_cnt++;
        issue(16'hFFFF, 16'h0002, 1'b0);
        wait_done(cyc, bcnt, ok, ov);
        total_cnt++;
        if (!ok || OUT !== 32'h0001FFFE)
            $display("FAIL mode_unsigned: got %h want 0001fffe", OUT);
        else pass_cnt++;
    endtask

    task automatic test_signed_extremes();
        int cyc, bcnt;
        bit ok, ov;
        issue(16'h8000, 16'h8000, 1'b1);
        wait_done(cyc, bcnt, ok, ov);
        total_cnt++;
        if (!ok || OUT !== 32'h40000000)
            $display("FAIL min_x_min: got %h want 40000000", OUT);
        else pass_cnt++;
        issue(16'h8000, 16'h7FFF, 1'b1);
        wait_done(cyc, bcnt, ok, ov);
        total_cnt++;
        if (!ok || OUT !== 32'hC0008000)
            $display("FAIL min_x_max: got %h want c0008000", OUT);
        else pass_cnt++;
        issue(16'h0000, 16'h8000, 1'b1);
        wait_done(cyc, bcnt, ok, ov);
        total_cnt++;
        if (!ok || OUT !== 32'h00000000)
            $display("FAIL zero_x_min: got %h want 00000000", OUT);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        int cyc, bcnt;
        bit ok, ov;
        issue(16'h0003, 16'h0005, 1'b0);
        @(negedge clk);
        A = 16'h1234;
        B = 16'h1234;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(cyc, bcnt, ok, ov);
        total_cnt++;
        if (!ok || OUT !== 32'h0000000F)
            $display("FAIL busy_start_ignored: got %h want 0000000f", OUT);
        else pass_cnt++;
        total_cnt++;
        if (cyc != 15)
            $display("FAIL busy_start_latency: got %0d want 15", cyc);
        else pass_cnt++;
        // Still in the done cycle: start here must be accepted.
        A = 16'h0007;
        B = 16'hFFF9;
        sign = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        total_cnt++;
        if (busy !== 1'b1)
            $display("FAIL b2b_accept: busy got %b want 1", busy);
        else pass_cnt++;
        wait_done(cyc, bcnt, ok, ov);
        total_cnt++;
        if (!ok || OUT !== 32'hFFFFFFCF)
            $display("FAIL b2b_out: got %h want ffffffcf", OUT);
        else pass_cnt++;
        total_cnt++;
        if (cyc != 17)
            $display("FAIL b2b_latency: got %0d want 17", cyc);
        else pass_cnt++;
    endtask

    task automatic test_operand_hold();
        bit ok;
        int n;
        ok = 1'b0;
        issue(16'h1234, 16'h5678, 1'b0);
        for (n = 0; n < 100; n++) begin
            A = 16'hFFFF - A;
            B = B + 16'h1111;
            sign = ~sign;
            if (n == 3) start = 1'b1;
            if (n == 4) start = 1'b0;
            @(negedge clk);
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
        start = 1'b0;
        total_cnt++;
        if (!ok || OUT !== 32'h06260060)
            $display("FAIL operand_hold: got %h want 06260060", OUT);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_op();
        int cyc, bcnt;
        bit ok, ov;
        bit seen;
        issue(16'h00FF, 16'h00FF, 1'b0);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        total_cnt++;
        if (busy !== 1'b0 || done !== 1'b0)
            $display("FAIL midrst_flags: busy=%b done=%b want 0 0", busy, done);
        else pass_cnt++;
        total_cnt++;
        if (OUT !== 32'h0)
            $display("FAIL midrst_out: got %h want 00000000", OUT);
        else pass_cnt++;
        seen = 1'b0;
        repeat (25) begin
            @(negedge clk);
            if (done || busy) seen = 1'b1;
        end
        total_cnt++;
        if (seen)
            $display("FAIL midrst_no_done: activity got 1 want 0");
        else pass_cnt++;
        issue(16'h00FF, 16'h00FF, 1'b0);
        wait_done(cyc, bcnt, ok, ov);
        total_cnt++;
        if (!ok || OUT !== 32'h0000FE01)
            $display("FAIL midrst_rerun: got %h want 0000fe01", OUT);
        else pass_cnt++;
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        A = '0;
        B = '0;
        sign = 1'b0;
        test_reset();
        test_unsigned_max();
        test_mode();
        test_signed_extremes();
        test_back_to_back();
        test_operand_hold();
        test_reset_mid_op();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
